// File: rtl/obstacle_field_ctrl.sv
// Obstacle field controller for the falling-obstacle game.
// Spawns, moves, scores and collides NUM_OBS obstacle slots; runs the
// IDLE/RUN/OVER game FSM and produces a registered obstacle pixel mask.
// Ports:
//   CLOCK_50, reset     clock, synchronous active-high reset
//   frame_tick, start   1-cycle pulses: frame advance, new game
//   player_x/player_y   player top-left corner
//   pixel_x/pixel_y     pixel being fetched by the VGA controller
//   obs_drawing         pixel inside an active obstacle (1-cycle latency)
//   obs_active          per-slot active flags
//   obs_x_flat/y_flat   slot i position at [10i+9:10i]
//   playing, game_over  FSM state flags
//   hit                 1-cycle pulse on collision
//   score, max_score    saturating current and best score
module obstacle_field_ctrl #(
    parameter int NUM_OBS      = 4,
    parameter int OBS_W        = 32,
    parameter int OBS_H        = 32,
    parameter int PLAYER_W     = 32,
    parameter int PLAYER_H     = 32,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int SPAWN_PERIOD = 60,
    parameter int FALL_STEP    = 2,
    parameter int SCORE_W      = 7,
    parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   start,
    input  logic [9:0]             player_x,
    input  logic [9:0]             player_y,
    input  logic [9:0]             pixel_x,
    input  logic [9:0]             pixel_y,
    output logic                   obs_drawing,
    output logic [NUM_OBS-1:0]     obs_active,
    output logic [10*NUM_OBS-1:0]  obs_x_flat,
    output logic [10*NUM_OBS-1:0]  obs_y_flat,
    output logic                   playing,
    output logic                   game_over,
    output logic                   hit,
    output logic [SCORE_W-1:0]     score,
    output logic [SCORE_W-1:0]     max_score
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    localparam int TW =
        (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(SPAWN_PERIOD - 1);

    localparam logic [9:0]  X_SPAN = 10'(SCREEN_W - OBS_W);
    localparam logic [10:0] STEP11 = 11'(FALL_STEP);
    localparam logic [10:0] H_LIM  = 11'(SCREEN_H);
    localparam logic [10:0] OW11   = 11'(OBS_W);
    localparam logic [10:0] OH11   = 11'(OBS_H);
    localparam logic [10:0] PW11   = 11'(PLAYER_W);
    localparam logic [10:0] PH11   = 11'(PLAYER_H);

    localparam int SSW = SCORE_W + 4;
    localparam logic [SSW-1:0] S_SAT = SSW'((1 << SCORE_W) - 1);

    logic [1:0]          state;
    logic [9:0]          lfsr;
    logic [TW-1:0]       timer;
    logic [9:0]          ox [NUM_OBS];
    logic [9:0]          oy [NUM_OBS];
    logic [NUM_OBS-1:0]  act;

    logic [9:0]          ox_n [NUM_OBS];
    logic [9:0]          oy_n [NUM_OBS];
    logic [NUM_OBS-1:0]  act_n;
    logic [TW-1:0]       timer_n;
    logic [3:0]          exits;
    logic                spawn_done;
    logic                coll;
    logic [9:0]          spawn_x;
    logic [SSW-1:0]      ssum;
    logic [SCORE_W-1:0]  score_n;
    logic [SCORE_W-1:0]  max_n;
    logic                draw_n;

    // Fold the 0..1023 LFSR value into the legal x range.
    assign spawn_x = (lfsr > X_SPAN) ? lfsr - X_SPAN : lfsr;

    // One frame update: move, then spawn, then collide.
    always_comb begin
        ox_n       = ox;
        oy_n       = oy;
        act_n      = act;
        timer_n    = timer;
        exits      = 4'd0;
        spawn_done = 1'b0;
        coll       = 1'b0;

        for (int i = 0; i < NUM_OBS; i++) begin
            logic [10:0] ny;
            ny = {1'b0, oy[i]} + STEP11;
            if (act[i]) begin
                if (ny >= H_LIM) begin
                    act_n[i] = 1'b0;
                    exits    = exits + 4'd1;
                end else begin
                    oy_n[i] = ny[9:0];
                end
            end
        end

        if (timer == T_LAST) begin
            timer_n = '0;
            for (int i = 0; i < NUM_OBS; i++) begin
                if (!act_n[i] && !spawn_done) begin
                    act_n[i]   = 1'b1;
                    ox_n[i]    = spawn_x;
                    oy_n[i]    = 10'd0;
                    spawn_done = 1'b1;
                end
            end
        end else begin
            timer_n = timer + 1'b1;
        end

        for (int i = 0; i < NUM_OBS; i++) begin
            logic [10:0] x1;
            logic [10:0] y1;
            logic [10:0] px;
            logic [10:0] py;
            x1 = {1'b0, ox_n[i]};
            y1 = {1'b0, oy_n[i]};
            px = {1'b0, player_x};
            py = {1'b0, player_y};
            if (act_n[i]
                && (x1 < px + PW11)
                && (px < x1 + OW11)
                && (y1 < py + PH11)
                && (py < y1 + OH11))
                coll = 1'b1;
        end
    end

    always_comb begin
        ssum = SSW'(score) + SSW'(exits);
        if (ssum > S_SAT)
            score_n = S_SAT[SCORE_W-1:0];
        else
            score_n = ssum[SCORE_W-1:0];
        max_n = (score_n > max_score) ? score_n : max_score;
    end

    always_comb begin
        draw_n = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            logic [10:0] x1;
            logic [10:0] y1;
            logic [10:0] qx;
            logic [10:0] qy;
            x1 = {1'b0, ox[i]};
            y1 = {1'b0, oy[i]};
            qx = {1'b0, pixel_x};
            qy = {1'b0, pixel_y};
            if (act[i]
                && (qx >= x1) && (qx < x1 + OW11)
                && (qy >= y1) && (qy < y1 + OH11))
                draw_n = 1'b1;
        end
        if (state == S_IDLE)
            draw_n = 1'b0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= S_IDLE;
            lfsr        <= LFSR_SEED;
            timer       <= '0;
            act         <= '0;
            score       <= '0;
            max_score   <= '0;
            hit         <= 1'b0;
            obs_drawing <= 1'b0;
            for (int i = 0; i < NUM_OBS; i++) begin
                ox[i] <= '0;
                oy[i] <= '0;
            end
        end else begin
            lfsr        <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            hit         <= 1'b0;
            obs_drawing <= draw_n;
            unique case (1'b1)
                (state != S_RUN) && start: begin
                    state <= S_RUN;
                    timer <= '0;
                    act   <= '0;
                    score <= '0;
                    for (int i = 0; i < NUM_OBS; i++) begin
                        ox[i] <= '0;
                        oy[i] <= '0;
                    end
                end
                (state == S_RUN) && frame_tick: begin
                    timer <= timer_n;
                    act   <= act_n;
                    score <= score_n;
                    ox    <= ox_n;
                    oy    <= oy_n;
                    if (coll) begin
                        state     <= S_OVER;
                        hit       <= 1'b1;
                        max_score <= max_n;
                    end
                end
                default: ;
            endcase
        end
    end

    assign obs_active = act;
    assign playing    = (state == S_RUN);
    assign game_over  = (state == S_OVER);

    for (genvar g = 0; g < NUM_OBS; g++) begin : g_flat
        assign obs_x_flat[10*g +: 10] = ox[g];
        assign obs_y_flat[10*g +: 10] = oy[g];
    end

endmodule

// File: tb/tb_obstacle_field_ctrl.sv
// Randomized bench for obstacle_field_ctrl.
// Compares the DUT every cycle against a behavioural game model.
module tb_obstacle_field_ctrl;

    localparam int N   = 4;
    localparam int SP  = 4;
    localparam int FS  = 16;
    localparam int SW  = 7;
    localparam int OW  = 32;
    localparam int OH  = 32;
    localparam int PW  = 32;
    localparam int PH  = 32;
    localparam int SCW = 640;
    localparam int SCH = 480;
    localparam int SMAX = (1 << SW) - 1;
    localparam int SEED = 'h2A5;

    logic CLOCK_50 = 1'b0;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic start = 1'b0;
    logic [9:0] player_x = 10'd0;
    logic [9:0] player_y = 10'd1000;
    logic [9:0] pixel_x = 10'd0;
    logic [9:0] pixel_y = 10'd0;
    logic obs_drawing;
    logic [N-1:0] obs_active;
    logic [10*N-1:0] obs_x_flat;
    logic [10*N-1:0] obs_y_flat;
    logic playing;
    logic game_over;
    logic hit;
    logic [SW-1:0] score;
    logic [SW-1:0] max_score;

    obstacle_field_ctrl #(
        .NUM_OBS(N),
        .SPAWN_PERIOD(SP),
        .FALL_STEP(FS)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .frame_tick(frame_tick),
        .start(start),
        .player_x(player_x),
        .player_y(player_y),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .obs_drawing(obs_drawing),
        .obs_active(obs_active),
        .obs_x_flat(obs_x_flat),
        .obs_y_flat(obs_y_flat),
        .playing(playing),
        .game_over(game_over),
        .hit(hit),
        .score(score),
        .max_score(max_score)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef enum int {M_IDLE, M_RUN, M_OVER} mstate_t;

    mstate_t m_state;
    int  m_x [N];
    int  m_y [N];
    bit  m_act [N];
    int  m_score;
    int  m_max;
    int  m_timer;
    int  m_lfsr;
    bit  m_hit;
    bit  m_draw;

    int  n_chk = 0;
    int  n_pass = 0;
    bit  rnd_pix = 1'b0;

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    endtask

    function automatic int lfsr_next(int l);
        return ((l << 1) & 1023) | (((l >> 9) ^ (l >> 6)) & 1);
    endfunction

    function automatic bit inside_box(int qx, int qy, int bx, int by,
                                      int w, int h);
        return qx >= bx && qx < bx + w && qy >= by && qy < by + h;
    endfunction

    task automatic model_step();
        bit nd;
        int px;
        int py;
        if (reset) begin
            m_state = M_IDLE;
            m_score = 0;
            m_max   = 0;
            m_timer = 0;
            m_lfsr  = SEED;
            m_hit   = 0;
            m_draw  = 0;
            for (int i = 0; i < N; i++) begin
                m_act[i] = 0;
                m_x[i]   = 0;
                m_y[i]   = 0;
            end
            return;
        end
        nd = 0;
        if (m_state != M_IDLE)
            for (int i = 0; i < N; i++)
                if (m_act[i] && inside_box(pixel_x, pixel_y,
                                           m_x[i], m_y[i], OW, OH))
                    nd = 1;
        m_hit = 0;
        px = int'(player_x);
        py = int'(player_y);
        if (m_state != M_RUN && start) begin
            m_state = M_RUN;
            m_score = 0;
            m_timer = 0;
            for (int i = 0; i < N; i++) begin
                m_act[i] = 0;
                m_x[i]   = 0;
                m_y[i]   = 0;
            end
        end else if (m_state == M_RUN && frame_tick) begin
            int  exits;
            bit  coll;
            exits = 0;
            coll  = 0;
            for (int i = 0; i < N; i++)
                if (m_act[i]) begin
                    if (m_y[i] + FS >= SCH) begin
                        m_act[i] = 0;
                        exits++;
                    end else begin
                        m_y[i] += FS;
                    end
                end
            if (m_timer == SP - 1) begin
                m_timer = 0;
                for (int i = 0; i < N; i++)
                    if (!m_act[i]) begin
                        m_act[i] = 1;
                        m_x[i] = (m_lfsr > SCW - OW) ?
                                 m_lfsr - (SCW - OW) : m_lfsr;
                        m_y[i] = 0;
                        break;
                    end
            end else begin
                m_timer++;
            end
            for (int i = 0; i < N; i++)
                if (m_act[i]
                    && m_x[i] < px + PW && px < m_x[i] + OW
                    && m_y[i] < py + PH && py < m_y[i] + OH)
                    coll = 1;
            m_score = (m_score + exits > SMAX) ? SMAX : m_score + exits;
            if (coll) begin
                m_state = M_OVER;
                m_hit   = 1;
                if (m_score > m_max) m_max = m_score;
            end
        end
        m_lfsr = lfsr_next(m_lfsr);
        m_draw = nd;
    endtask

    function automatic int act_vec();
        int v;
        v = 0;
        for (int i = 0; i < N; i++)
            if (m_act[i]) v |= (1 << i);
        return v;
    endfunction

    task automatic check_all();
        chk("playing", playing, m_state == M_RUN);
        chk("game_over", game_over, m_state == M_OVER);
        chk("hit", hit, m_hit);
        chk("score", score, m_score);
        chk("max_score", max_score, m_max);
        chk("obs_active", obs_active, act_vec());
        chk("obs_drawing", obs_drawing, m_draw);
        for (int i = 0; i < N; i++)
            if (m_act[i]) begin
                chk($sformatf("x%0d", i),
                    obs_x_flat[10*i +: 10], m_x[i]);
                chk($sformatf("y%0d", i),
                    obs_y_flat[10*i +: 10], m_y[i]);
            end
    endtask

    task automatic rand_pixel();
        int k;
        k = $urandom_range(0, N - 1);
        if ($urandom_range(0, 1) == 1 && m_act[k]) begin
            pixel_x = 10'(m_x[k] + $urandom_range(0, OW + 8) - 4);
            pixel_y = 10'(m_y[k] + $urandom_range(0, OH + 8) - 4);
        end else begin
            pixel_x = 10'($urandom_range(0, 1023));
            pixel_y = 10'($urandom_range(0, 1023));
        end
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        model_step();
        #1;
        check_all();
        if (rnd_pix) rand_pixel();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
    endtask

    initial begin
        logic [10*N-1:0] exp_y;

        reset = 1'b1;
        repeat (3) cycle();
        chk("rst_playing", playing, 0);
        chk("rst_act", obs_active, 0);
        chk("rst_score", score, 0);
        chk("rst_max", max_score, 0);
        chk("rst_draw", obs_drawing, 0);
        chk("rst_xy", int'(obs_x_flat != 0 || obs_y_flat != 0), 0);
        reset = 1'b0;
        cycle();

        player_x = 10'd0;
        player_y = 10'd1000;
        pulse_start();
        repeat (4) tick();
        chk("spawn_act0", obs_active[0], 1);
        chk("spawn_y0", obs_y_flat[9:0], 0);
        chk("spawn_xrange", int'(obs_x_flat[9:0] <= 10'd608), 1);
        repeat (16) tick();
        chk("full_act", obs_active, 4'hF);
        chk("full_y0", obs_y_flat[9:0], 256);
        repeat (13) tick();
        chk("fall_y464", obs_y_flat[9:0], 464);
        tick();
        chk("exit_act0", obs_active[0], 0);
        chk("exit_score", score, 1);

        pixel_x = 10'(m_x[1]);
        pixel_y = 10'(m_y[1]);
        cycle();
        chk("draw_corner", obs_drawing, 1);
        pixel_x = 10'(m_x[1] + OW);
        cycle();
        chk("draw_right_edge", obs_drawing, m_draw);
        pixel_x = 10'(m_x[1] + OW - 1);
        pixel_y = 10'(m_y[1] + OH - 1);
        cycle();
        chk("draw_far_corner", obs_drawing, 1);

        player_x = 10'(m_x[1]);
        player_y = 10'(m_y[1] + FS);
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        chk("coll_hit", hit, 1);
        chk("coll_over", game_over, 1);
        chk("coll_max", max_score, 1);
        cycle();
        chk("coll_hit_pulse", hit, 0);
        repeat (3) tick();
        exp_y = '0;
        for (int i = 0; i < N; i++)
            exp_y[10*i +: 10] = 10'(m_y[i]);
        chk("over_frozen", int'(obs_y_flat == exp_y), 1);
        chk("over_still", game_over, 1);

        start = 1'b1;
        frame_tick = 1'b1;
        cycle();
        start = 1'b0;
        frame_tick = 1'b0;
        cycle();
        chk("restart_score", score, 0);
        chk("restart_act", obs_active, 0);
        chk("restart_max", max_score, 1);
        chk("restart_play", playing, 1);
        repeat (3) tick();
        chk("restart_nospawn", obs_active, 0);
        tick();
        chk("restart_spawn", obs_active, 1);

        player_y = 10'd1000;
        rnd_pix = 1'b1;
        repeat (1300) tick();
        chk("sat_score", score, SMAX);
        chk("sat_play", playing, 1);

        for (int c = 0; c < 5000; c++) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            start = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 3) == 0) begin
                player_x = 10'($urandom_range(0, SCW));
                player_y = 10'($urandom_range(0, SCH));
            end else begin
                player_y = 10'd1000;
            end
            cycle();
        end
        frame_tick = 1'b0;
        start = 1'b0;
        reset = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
